// File: rtl/guess_judge_if.sv
// guess_judge_if: command/result bundle between the round controller and the
// judge. The master drives the commands; the slave (the judge) drives the LED
// codes and the round status.
interface guess_judge_if #(
  parameter int LETTER_W = 5
);
  logic                  new_game;
  logic [5*LETTER_W-1:0] answer;
  logic                  submit;
  logic [5*LETTER_W-1:0] guess;
  logic [2:0]            led1;
  logic [2:0]            led2;
  logic [2:0]            led3;
  logic [2:0]            led4;
  logic [2:0]            led5;
  logic [1:0]            state;
  logic                  warning;
  logic                  busy;
  logic                  done;
  logic [2:0]            attempts;

  modport master (
    output new_game, answer, submit, guess,
    input  led1, led2, led3, led4, led5, state, warning, busy, done, attempts
  );

  modport slave (
    input  new_game, answer, submit, guess,
    output led1, led2, led3, led4, led5, state, warning, busy, done, attempts
  );
endinterface

// File: rtl/guess_judge.sv
// guess_judge: scores a 5-letter guess against the latched answer using
// duplicate-aware rules (exact pass first, then one present-elsewhere position
// per cycle), and keeps the round state and attempt count.
// Optional build macro HARD_MODE_EN: positions scored exact earlier in the
// round must keep the same letter in later guesses, or the submit is rejected.
//
// FSM states:
//   state   | meaning
//   IDLE    | no round in play (reset, bad answer, round won or lost)
//   READY   | round in play, waiting for a submit
//   EXACT   | marks exact matches and consumes those answer positions
//   PRESENT | one guess position per cycle, idx 0..4, lowest unused match
//   COMMIT  | publishes LED codes, bumps attempts, decides won/lost/ready
module guess_judge #(
  parameter int MAX_TRIES = 6,
  parameter int LETTER_W  = 5
) (
  input logic           clk,
  input logic           rst_n,
  guess_judge_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READY   = 3'd1;
  localparam logic [2:0] S_EXACT   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_WON  = 2'd2;
  localparam logic [1:0] ST_LOST = 2'd3;

  localparam logic [2:0] C_EXACT = 3'b100;
  localparam logic [2:0] C_PRES  = 3'b010;
  localparam logic [2:0] C_ABS   = 3'b001;

  localparam logic [2:0] MAX_ATT = 3'(MAX_TRIES);

  logic [2:0]                 fsm_q, fsm_d;
  logic [1:0]                 st_q, st_d;
  logic                       warn_q, warn_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [2:0]                 att_q, att_d;
  logic [4:0][LETTER_W-1:0]   ans_q, ans_d;
  logic [4:0][LETTER_W-1:0]   gss_q, gss_d;
  logic [4:0][2:0]            code_q, code_d;
  logic [4:0]                 used_q, used_d;
  logic [2:0]                 idx_q, idx_d;
  logic [4:0][2:0]            led_q, led_d;

  logic [4:0][LETTER_W-1:0]   ans_in;
  logic [4:0][LETTER_W-1:0]   gss_in;
  logic                       ans_in_ok;
  logic                       gss_in_ok;
  logic                       hard_ok;
  logic                       all_exact;
  logic [2:0]                 att_inc;

  logic [LETTER_W-1:0]        cur_let;
  logic [2:0]                 cur_code;
  logic                       pres_found;
  logic [2:0]                 pres_j;

`ifdef HARD_MODE_EN
  logic [4:0]                 green_q, green_d;
  logic [4:0][LETTER_W-1:0]   green_let_q, green_let_d;
`endif

  function automatic logic letter_ok(input logic [LETTER_W-1:0] l);
    return (l != '0) && (l <= LETTER_W'(26));
  endfunction

  assign ans_in = bus.answer;
  assign gss_in = bus.guess;

  assign bus.led1     = led_q[0];
  assign bus.led2     = led_q[1];
  assign bus.led3     = led_q[2];
  assign bus.led4     = led_q[3];
  assign bus.led5     = led_q[4];
  assign bus.state    = st_q;
  assign bus.warning  = warn_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.attempts = att_q;

  // Letter validity of the incoming answer and guess, plus the hard-mode gate.
  always_comb begin
    ans_in_ok = 1'b1;
    gss_in_ok = 1'b1;
    hard_ok   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!letter_ok(ans_in[i])) ans_in_ok = 1'b0;
      if (!letter_ok(gss_in[i])) gss_in_ok = 1'b0;
`ifdef HARD_MODE_EN
      if (green_q[i] && (gss_in[i] != green_let_q[i])) hard_ok = 1'b0;
`endif
    end
  end

  // Present-elsewhere search for the position selected by idx: lowest unused
  // answer position holding the same letter wins.
  always_comb begin
    cur_let    = '0;
    cur_code   = C_ABS;
    pres_found = 1'b0;
    pres_j     = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (idx_q == 3'(i)) begin
        cur_let  = gss_q[i];
        cur_code = code_q[i];
      end
    end
    for (int j = 4; j >= 0; j--) begin
      if (!used_q[j] && (ans_q[j] == cur_let)) begin
        pres_found = 1'b1;
        pres_j     = 3'(j);
      end
    end
  end

  assign all_exact = (code_q == {5{C_EXACT}});
  assign att_inc   = (att_q < MAX_ATT) ? att_q + 3'd1 : att_q;

  // Next-state logic: evaluation pipeline, then submit handling, then
  // new_game which overrides everything including a simultaneous submit.
  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    warn_d = warn_q;
    busy_d = busy_q;
    done_d = 1'b0;
    att_d  = att_q;
    ans_d  = ans_q;
    gss_d  = gss_q;
    code_d = code_q;
    used_d = used_q;
    idx_d  = idx_q;
    led_d  = led_q;
`ifdef HARD_MODE_EN
    green_d     = green_q;
    green_let_d = green_let_q;
`endif

    case (fsm_q)
      S_EXACT: begin
        for (int i = 0; i < 5; i++) begin
          if (gss_q[i] == ans_q[i]) begin
            code_d[i] = C_EXACT;
            used_d[i] = 1'b1;
          end
        end
        idx_d = 3'd0;
        fsm_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (cur_code != C_EXACT) begin
          for (int i = 0; i < 5; i++) begin
            if (idx_q == 3'(i)) code_d[i] = pres_found ? C_PRES : C_ABS;
            if (pres_found && (pres_j == 3'(i))) used_d[i] = 1'b1;
          end
        end
        if (idx_q == 3'd4) begin
          fsm_d = S_COMMIT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_COMMIT: begin
        led_d  = code_q;
        att_d  = att_inc;
        done_d = 1'b1;
        busy_d = 1'b0;
`ifdef HARD_MODE_EN
        for (int i = 0; i < 5; i++) begin
          if (code_q[i] == C_EXACT) begin
            green_d[i]     = 1'b1;
            green_let_d[i] = gss_q[i];
          end
        end
`endif
        if (all_exact) begin
          st_d  = ST_WON;
          fsm_d = S_IDLE;
        end else if (att_inc >= MAX_ATT) begin
          st_d  = ST_LOST;
          fsm_d = S_IDLE;
        end else begin
          fsm_d = S_READY;
        end
      end
      default: ;
    endcase

    if (bus.submit) begin
      if ((fsm_q == S_READY) && (st_q == ST_PLAY) && gss_in_ok && hard_ok) begin
        gss_d  = gss_in;
        warn_d = 1'b0;
        busy_d = 1'b1;
        code_d = {5{C_ABS}};
        used_d = '0;
        fsm_d  = S_EXACT;
      end else begin
        warn_d = 1'b1;
      end
    end

    if (bus.new_game) begin
      ans_d  = ans_in;
      att_d  = 3'd0;
      led_d  = {5{C_ABS}};
      code_d = {5{C_ABS}};
      used_d = '0;
      idx_d  = 3'd0;
      busy_d = 1'b0;
      done_d = 1'b0;
`ifdef HARD_MODE_EN
      green_d     = '0;
      green_let_d = '0;
`endif
      if (ans_in_ok) begin
        st_d   = ST_PLAY;
        warn_d = 1'b0;
        fsm_d  = S_READY;
      end else begin
        st_d   = ST_IDLE;
        warn_d = 1'b1;
        fsm_d  = S_IDLE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= S_IDLE;
      st_q   <= ST_IDLE;
      warn_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      att_q  <= 3'd0;
      ans_q  <= '0;
      gss_q  <= '0;
      code_q <= {5{C_ABS}};
      used_q <= '0;
      idx_q  <= 3'd0;
      led_q  <= {5{C_ABS}};
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      warn_q <= warn_d;
      busy_q <= busy_d;
      done_q <= done_d;
      att_q  <= att_d;
      ans_q  <= ans_d;
      gss_q  <= gss_d;
      code_q <= code_d;
      used_q <= used_d;
      idx_q  <= idx_d;
      led_q  <= led_d;
    end
  end

`ifdef HARD_MODE_EN
  // Green-position mask and the letters it pins for the rest of the round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      green_q     <= '0;
      green_let_q <= '0;
    end else begin
      green_q     <= green_d;
      green_let_q <= green_let_d;
    end
  end
`endif

endmodule

// File: tb/tb_guess_judge.sv
// tb_guess_judge: directed stimulus; each accepted submit pushes its expected
// LED codes, state, attempts and commit cycle onto a scoreboard that a
// separate monitor pops whenever done is seen.
module tb_guess_judge;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  guess_judge_if #(.LETTER_W(5)) bus ();

  guess_judge #(.MAX_TRIES(6), .LETTER_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [14:0] leds;
    logic [1:0]  st;
    logic [2:0]  att;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [2:0] E = 3'b100;
  localparam logic [2:0] P = 3'b010;
  localparam logic [2:0] A = 3'b001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  function automatic logic [24:0] w(input logic [4:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [14:0] lc(input logic [2:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_leds", 32'({bus.led5, bus.led4, bus.led3, bus.led2, bus.led1}), 32'(mon_e.leds));
        chk("done_state", 32'(bus.state), 32'(mon_e.st));
        chk("done_attempts", 32'(bus.attempts), 32'(mon_e.att));
        chk("done_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic start(input logic [24:0] ans);
    bus.answer   = ans;
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
  endtask

  task automatic do_guess(input string nm, input logic [24:0] g, input logic [14:0] el,
                          input logic [1:0] es, input logic [2:0] ea);
    int n;
    sb.push_back('{el, es, ea, cyc + 8});
    bus.guess  = g;
    bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
    chk({nm, "_warn_clr"}, 32'(bus.warning), 32'd0);
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_busy_len"}, 32'(n), 32'd7);
  endtask

  task automatic reject(input string nm, input logic [24:0] g, input logic [2:0] ea,
                        input logic [1:0] es);
    bus.guess  = g;
    bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    chk({nm, "_warn"}, 32'(bus.warning), 32'd1);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_att"}, 32'(bus.attempts), 32'(ea));
    chk({nm, "_state"}, 32'(bus.state), 32'(es));
    repeat (9) tick();
  endtask

  logic [24:0] apple, paper, puppy, xxxxx;

  initial begin
    apple = w(1, 16, 16, 12, 5);
    paper = w(16, 1, 16, 5, 18);
    puppy = w(16, 21, 16, 16, 25);
    xxxxx = w(24, 24, 24, 24, 24);
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.new_game = 1'b0; bus.submit = 1'b0; bus.answer = '0; bus.guess = '0;
    tick(); tick();
    chk("rst_leds", 32'({bus.led5, bus.led4, bus.led3, bus.led2, bus.led1}), 32'(lc(A, A, A, A, A)));
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_warn", 32'(bus.warning), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_att", 32'(bus.attempts), 32'd0);
    rst_n = 1'b1;
    tick();

    // Submit while idle is rejected.
    reject("idle_submit", paper, 3'd0, 2'd0);

    // Basic scoring and duplicates.
    start(apple);
    chk("ng_state", 32'(bus.state), 32'd1);
    chk("ng_warn", 32'(bus.warning), 32'd0);
    do_guess("paper", paper, lc(P, P, E, P, A), 2'd1, 3'd1);
    start(apple);
    chk("ng2_att", 32'(bus.attempts), 32'd0);
    do_guess("puppy", puppy, lc(P, A, E, A, A), 2'd1, 3'd1);

    // Invalid letters rejected, then a valid submit clears warning.
    reject("letter0", w(1, 0, 16, 12, 5), 3'd1, 2'd1);
    reject("letter27", w(1, 27, 16, 12, 5), 3'd1, 2'd1);
    do_guess("after_rej", xxxxx, lc(A, A, A, A, A), 2'd1, 3'd2);

    // Submit while busy: warning set, running evaluation unaffected.
    sb.push_back('{lc(P, P, E, P, A), 2'd1, 3'd3, cyc + 8});
    bus.guess = paper; bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    tick();
    bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    chk("busy_submit_warn", 32'(bus.warning), 32'd1);
    begin
      int n = 0;
      while (bus.busy && n < 20) begin tick(); n++; end
      chk("busy_submit_drain", 32'(n), 32'd5);
    end
    tick();

    // Win, then further submit rejected.
    start(apple);
    do_guess("win", apple, lc(E, E, E, E, E), 2'd2, 3'd1);
    reject("after_win", paper, 3'd1, 2'd2);

    // Loss after six misses, then further submit rejected.
    start(apple);
    do_guess("miss1", w(2, 2, 2, 2, 2), lc(A, A, A, A, A), 2'd1, 3'd1);
    do_guess("miss2", w(3, 3, 3, 3, 3), lc(A, A, A, A, A), 2'd1, 3'd2);
    do_guess("miss3", w(4, 4, 4, 4, 4), lc(A, A, A, A, A), 2'd1, 3'd3);
    do_guess("miss4", w(6, 6, 6, 6, 6), lc(A, A, A, A, A), 2'd1, 3'd4);
    do_guess("miss5", w(7, 7, 7, 7, 7), lc(A, A, A, A, A), 2'd1, 3'd5);
    do_guess("miss6", w(8, 8, 8, 8, 8), lc(A, A, A, A, A), 2'd3, 3'd6);
    reject("after_loss", paper, 3'd6, 2'd3);

    // Abort mid-PRESENT with simultaneous submit.
    start(apple);
    do_guess("pre_abort", paper, lc(P, P, E, P, A), 2'd1, 3'd1);
    bus.guess = puppy; bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    repeat (3) tick();
    bus.answer = apple; bus.new_game = 1'b1; bus.submit = 1'b1;
    tick();
    bus.new_game = 1'b0; bus.submit = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_leds", 32'({bus.led5, bus.led4, bus.led3, bus.led2, bus.led1}), 32'(lc(A, A, A, A, A)));
    chk("abort_att", 32'(bus.attempts), 32'd0);
    chk("abort_state", 32'(bus.state), 32'd1);
    chk("abort_warn", 32'(bus.warning), 32'd0);
    repeat (10) tick();

    // Hard mode: green P at position 2 must persist.
    start(apple);
    do_guess("hm_paper", paper, lc(P, P, E, P, A), 2'd1, 3'd1);
`ifdef HARD_MODE_EN
    reject("hm_violate", xxxxx, 3'd1, 2'd1);
    do_guess("hm_ok", w(24, 24, 16, 24, 24), lc(A, A, E, A, A), 2'd1, 3'd2);
`else
    do_guess("hm_off", xxxxx, lc(A, A, A, A, A), 2'd1, 3'd2);
`endif

    // Invalid answer: idle with warning; submit rejected.
    start(w(1, 16, 0, 12, 5));
    chk("badans_state", 32'(bus.state), 32'd0);
    chk("badans_warn", 32'(bus.warning), 32'd1);
    reject("badans_submit", paper, 3'd0, 2'd0);

    // Async reset mid-evaluation.
    start(apple);
    bus.guess = paper; bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_att", 32'(bus.attempts), 32'd0);
    chk("arst_leds", 32'({bus.led5, bus.led4, bus.led3, bus.led2, bus.led1}), 32'(lc(A, A, A, A, A)));
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/guess_judge.md
Name: guess_judge

Overview:
- Scores one submitted 5-letter guess against the latched answer of the current round.
- Applies Wordle duplicate rules: exact matches first, then present-elsewhere matches, each answer letter consumed at most once.
- Drives the per-position 3-bit LED codes, the 2-bit game state and the warning flag consumed directly by the downstream LED driver.
- Also keeps the attempt count for the round.

Parameters:
- MAX_TRIES, 6: guesses allowed per round before the round is lost.
- LETTER_W, 5: bits per letter code; 1..26 = A..Z, 0 and 27..31 invalid.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- new_game  in  1  one-cycle pulse; latch answer, start round
- answer  in  5*LETTER_W  answer letters, position 0 in LSBs
- submit  in  1  one-cycle pulse; evaluate guess
- guess  in  5*LETTER_W  guess letters, position 0 in LSBs
- led1..led5  out  3 each  per-position code: 3'b100 exact, 3'b010 present elsewhere, 3'b001 absent/off
- state  out  2  0 idle, 1 playing, 2 won, 3 lost
- warning  out  1  last request rejected
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse when the LED codes and state commit
- attempts  out  3  accepted guesses this round

Behaviour:
- Reset values: led1..led5 = 3'b001; state = 0; warning = 0; busy = 0; done = 0; attempts = 0; FSM = IDLE.
- FSM states: IDLE, READY, EXACT, PRESENT, COMMIT.
- new_game, sampled in any FSM state:
  - Aborts any evaluation in progress and latches answer.
  - All five answer letters valid: state = 1, FSM = READY.
  - Otherwise: state = 0, warning = 1, FSM = IDLE.
  - In both cases: attempts = 0, leds = 3'b001, busy = 0.
  - new_game has priority over a simultaneous submit; that submit is dropped with no warning.
- submit is accepted only in READY with state = 1 and all five guess letters valid.
  - On the sampling edge: guess is latched, warning is cleared, busy goes to 1, FSM goes to EXACT.
- submit is rejected in every other case: IDLE, busy, state 2 or 3, or any invalid letter.
  - Rejection sets warning = 1. Nothing else changes, and attempts is not incremented.
- EXACT, 1 cycle:
  - Position i whose guess letter equals the answer letter gets code 100.
  - That answer position is marked used.
- PRESENT, 5 cycles, index i = 0..4 in ascending order, one position per cycle:
  - Positions that already have code 100 are skipped.
  - Otherwise, search for the lowest unused answer position j whose letter equals guess[i].
  - Found: code 010 and mark j used. Not found: code 001.
- COMMIT, 1 cycle:
  - Register led1..led5, increment attempts, pulse done, clear busy.
  - All five codes 100: state = 2, FSM = IDLE.
  - Else if attempts reaches MAX_TRIES: state = 3, FSM = IDLE.
  - Else FSM returns to READY.
- Latency: the LED codes, state and done change on the 7th rising edge after the edge that samples submit; busy is high for exactly those 7 cycles.
- The LED codes hold their values between evaluations and never glitch mid-evaluation.
- attempts saturates at MAX_TRIES and never wraps.
- warning is sticky until the next accepted submit or a valid new_game.
- Asynchronous reset mid-evaluation returns everything to reset values immediately.

Optional Feature:
- Macro: HARD_MODE_EN.
- When defined:
  - Every position scored 100 in an earlier guess of the round must repeat the same letter in later guesses.
  - A violating submit is rejected: warning = 1, no evaluation, attempts unchanged.
  - The green-position mask and its letters are cleared on new_game.
- When undefined: no constraint and no mask storage.

Test Plan:
- Basic scoring: reset; new_game answer APPLE (1,16,16,12,5); submit PAPER (16,1,16,5,18) -> after 7 edges: led1..5 = 010,010,100,010,001; done pulse; attempts = 1; state = 1.
- Duplicate letters: answer APPLE; submit PUPPY (16,21,16,16,25) -> led1..5 = 010,001,100,001,001.
- Win: answer APPLE; submit APPLE -> all codes 100; state = 2. A further submit -> warning = 1, attempts unchanged.
- Loss and reject:
  - Six non-matching valid guesses -> state = 3 after the 6th done; attempts = 6.
  - A guess containing letter 0 -> warning = 1, no done pulse.
- Abort and priority: new_game asserted mid-PRESENT, together with a submit -> busy drops, leds = 001, attempts = 0, state = 1, no done, warning = 0.
- Hard mode (HARD_MODE_EN defined): answer APPLE; submit PAPER, then submit XXXXX (24 x5) -> second submit rejected, warning = 1, attempts stays 1.
